// File: rtl/red_pitaya_pwr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : red_pitaya_pwr_pkg
//  Purpose  : Shared constants for the power-test burst scheduler:
//             FSM state encoding, default stage count and the burst-entry
//             helper.
//  Revision : 1.0  initial release
// ============================================================================
package red_pitaya_pwr_pkg;

   localparam int unsigned c_STAGES_DEFAULT = 4;

   localparam logic [2:0] c_ST_IDLE = 3'd0;
   localparam logic [2:0] c_ST_RAMP = 3'd1;
   localparam logic [2:0] c_ST_ON   = 3'd2;
   localparam logic [2:0] c_ST_OFF  = 3'd3;
   localparam logic [2:0] c_ST_DONE = 3'd4;

   // Every burst starts with a soft ramp unless the ramp step period is zero.
   function automatic logic [2:0] burst_entry(input logic i_ramp_nz);
      return i_ramp_nz ? c_ST_RAMP : c_ST_ON;
   endfunction

endpackage
`default_nettype wire

// File: rtl/red_pitaya_pwr_timer.sv
`default_nettype none
// ============================================================================
//  Module   : red_pitaya_pwr_timer
//  Purpose  : Loadable down-counter. Loaded with period-1, counts down while
//             enabled and flags expiry when it reaches zero, so a period of
//             P cycles is P samples of the owning state.
//  Revision : 1.0  initial release
// ============================================================================
module red_pitaya_pwr_timer #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         i_load,
   input  logic         i_en,
   input  logic [W-1:0] i_load_val,
   output logic         o_expire
);

   logic [W-1:0] r_cnt;

   // Load has priority; otherwise count down while enabled, holding at zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_expire = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/red_pitaya_pwr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : red_pitaya_pwr_sched
//  Purpose  : Burst scheduler for the power-consumption test load. Runs N
//             on/off bursts, each preceded by a staged soft ramp, and drives
//             load enable, thermometer stage enables and the seed reload.
//  Revision : 1.0  initial release
// ============================================================================
module red_pitaya_pwr_sched
   import red_pitaya_pwr_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int STEP_W  = 16,
   parameter int STAGES  = c_STAGES_DEFAULT,
   parameter int BURST_W = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic [CNT_W-1:0]   on_cyc_i,
   input  logic [CNT_W-1:0]   off_cyc_i,
   input  logic [STEP_W-1:0]  ramp_cyc_i,
   input  logic [BURST_W-1:0] bursts_i,
   input  logic [31:0]        seed_i,
   output logic               load_en_o,
   output logic [STAGES-1:0]  stage_en_o,
   output logic [31:0]        seed_o,
   output logic               seed_wr_o,
   output logic               busy_o,
   output logic               done_o,
   output logic [BURST_W-1:0] burst_cnt_o
);

   localparam int c_SIDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;

   logic [2:0]          r_state;
   logic [c_SIDX_W-1:0] r_stage;
   logic [CNT_W-1:0]    r_on;
   logic [CNT_W-1:0]    r_off;
   logic [STEP_W-1:0]   r_ramp;
   logic [BURST_W-1:0]  r_bursts;
   logic [31:0]         r_seed;
   logic                r_seed_wr;
   logic [BURST_W-1:0]  r_burst_cnt;

   logic [2:0]          w_nxt;
   logic [c_SIDX_W-1:0] w_stage_nxt;
   logic                w_cnt_inc;
   logic                w_enter_burst;
   logic                w_tmr_load;
   logic [CNT_W-1:0]    w_tmr_val;
   logic                w_stp_load;
   logic [STEP_W-1:0]   w_stp_val;
   logic                w_tmr_exp;
   logic                w_stp_exp;
   logic                w_start_ok;
   logic [BURST_W-1:0]  w_cnt_p1;

   assign w_start_ok = (r_state == c_ST_IDLE) && start_i && !abort_i;
   assign w_cnt_p1   = r_burst_cnt + BURST_W'(1);

   // Shared on/off period timer.
   red_pitaya_pwr_timer #(.W(CNT_W)) u_tmr_onoff (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .i_load     (w_tmr_load),
      .i_en       ((r_state == c_ST_ON) || (r_state == c_ST_OFF)),
      .i_load_val (w_tmr_val),
      .o_expire   (w_tmr_exp)
   );

   // Ramp step timer; r_stage tracks which step is active.
   red_pitaya_pwr_timer #(.W(STEP_W)) u_tmr_step (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .i_load     (w_stp_load),
      .i_en       (r_state == c_ST_RAMP),
      .i_load_val (w_stp_val),
      .o_expire   (w_stp_exp)
   );

   // Next-state, timer reload and burst-count decisions; abort beats expiry.
   always_comb begin
      w_nxt         = r_state;
      w_stage_nxt   = r_stage;
      w_cnt_inc     = 1'b0;
      w_enter_burst = 1'b0;
      w_tmr_load    = 1'b0;
      w_tmr_val     = '0;
      w_stp_load    = 1'b0;
      w_stp_val     = '0;
      case (r_state)
         c_ST_IDLE: begin
            if (w_start_ok) begin
               if (on_cyc_i == '0) begin
                  w_nxt = c_ST_DONE;
               end else if (ramp_cyc_i != '0) begin
                  w_nxt       = c_ST_RAMP;
                  w_stage_nxt = '0;
                  w_stp_load  = 1'b1;
                  w_stp_val   = ramp_cyc_i - STEP_W'(1);
               end else begin
                  w_nxt      = c_ST_ON;
                  w_tmr_load = 1'b1;
                  w_tmr_val  = on_cyc_i - CNT_W'(1);
               end
            end
         end
         c_ST_RAMP: begin
            if (abort_i) begin
               w_nxt = c_ST_DONE;
            end else if (w_stp_exp) begin
               if (r_stage == c_SIDX_W'(STAGES - 1)) begin
                  w_nxt      = c_ST_ON;
                  w_tmr_load = 1'b1;
                  w_tmr_val  = r_on - CNT_W'(1);
               end else begin
                  w_stage_nxt = r_stage + c_SIDX_W'(1);
                  w_stp_load  = 1'b1;
                  w_stp_val   = r_ramp - STEP_W'(1);
               end
            end
         end
         c_ST_ON: begin
            if (abort_i) begin
               w_nxt = c_ST_DONE;
            end else if (w_tmr_exp) begin
               w_cnt_inc = 1'b1;
               if ((r_bursts != '0) && (w_cnt_p1 == r_bursts)) begin
                  w_nxt = c_ST_DONE;
               end else if (r_off != '0) begin
                  w_nxt      = c_ST_OFF;
                  w_tmr_load = 1'b1;
                  w_tmr_val  = r_off - CNT_W'(1);
               end else begin
                  w_enter_burst = 1'b1;
               end
            end
         end
         c_ST_OFF: begin
            if (abort_i) begin
               w_nxt = c_ST_DONE;
            end else if (w_tmr_exp) begin
               w_enter_burst = 1'b1;
            end
         end
         c_ST_DONE: w_nxt = c_ST_IDLE;
         default:   w_nxt = c_ST_IDLE;
      endcase
      if (w_enter_burst) begin
         w_nxt = burst_entry(r_ramp != '0);
         if (r_ramp != '0) begin
            w_stage_nxt = '0;
            w_stp_load  = 1'b1;
            w_stp_val   = r_ramp - STEP_W'(1);
         end else begin
            w_tmr_load = 1'b1;
            w_tmr_val  = r_on - CNT_W'(1);
         end
      end
   end

   // State, config latches, seed strobe and burst counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= c_ST_IDLE;
         r_stage     <= '0;
         r_on        <= '0;
         r_off       <= '0;
         r_ramp      <= '0;
         r_bursts    <= '0;
         r_seed      <= '0;
         r_seed_wr   <= 1'b0;
         r_burst_cnt <= '0;
      end else begin
         r_state   <= w_nxt;
         r_stage   <= w_stage_nxt;
         r_seed_wr <= w_start_ok && (on_cyc_i != '0);
         if (w_start_ok) begin
            r_on        <= on_cyc_i;
            r_off       <= off_cyc_i;
            r_ramp      <= ramp_cyc_i;
            r_bursts    <= bursts_i;
            r_seed      <= seed_i;
            r_burst_cnt <= '0;
         end else if (w_cnt_inc) begin
            r_burst_cnt <= w_cnt_p1;
         end
      end
   end

   // Thermometer stage enables: ramp step k lights stages 0..k, ON lights all.
   always_comb begin
      stage_en_o = '0;
      for (int i = 0; i < STAGES; i++) begin
         if (r_state == c_ST_ON) begin
            stage_en_o[i] = 1'b1;
         end else if (r_state == c_ST_RAMP) begin
            stage_en_o[i] = (c_SIDX_W'(i) <= r_stage);
         end
      end
   end

   assign load_en_o   = (r_state == c_ST_RAMP) || (r_state == c_ST_ON);
   assign busy_o      = (r_state != c_ST_IDLE);
   assign done_o      = (r_state == c_ST_DONE);
   assign seed_wr_o   = r_seed_wr;
   assign seed_o      = r_seed;
   assign burst_cnt_o = r_burst_cnt;

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_pwr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_red_pitaya_pwr_sched
//  Purpose  : Self-checking bench for red_pitaya_pwr_sched: cycle tables for
//             the plain and ramped burst sequences, directed sequences for
//             wrap, abort, zero-length, reset and busy corner cases.
//  Revision : 1.0  initial release
// ============================================================================
module tb_red_pitaya_pwr_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, abort, start4, abort4;
   logic [31:0] on_cyc, off_cyc, seed;
   logic [15:0] ramp_cyc, bursts;
   logic [3:0]  bursts4;

   logic        load_en, seed_wr, busy, done;
   logic [3:0]  stage_en;
   logic [31:0] seed_o;
   logic [15:0] cnt;

   logic        load_en4, seed_wr4, busy4, done4;
   logic [3:0]  stage_en4;
   logic [31:0] seed_o4;
   logic [3:0]  cnt4;

   red_pitaya_pwr_sched u_dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
      .on_cyc_i(on_cyc), .off_cyc_i(off_cyc), .ramp_cyc_i(ramp_cyc),
      .bursts_i(bursts), .seed_i(seed),
      .load_en_o(load_en), .stage_en_o(stage_en), .seed_o(seed_o),
      .seed_wr_o(seed_wr), .busy_o(busy), .done_o(done), .burst_cnt_o(cnt)
   );

   // Narrow burst counter instance so the wrap is reachable in a few cycles.
   red_pitaya_pwr_sched #(.BURST_W(4)) u_dut4 (
      .clk_i(clk), .rst_i(rst), .start_i(start4), .abort_i(abort4),
      .on_cyc_i(on_cyc), .off_cyc_i(off_cyc), .ramp_cyc_i(ramp_cyc),
      .bursts_i(bursts4), .seed_i(seed),
      .load_en_o(load_en4), .stage_en_o(stage_en4), .seed_o(seed_o4),
      .seed_wr_o(seed_wr4), .busy_o(busy4), .done_o(done4), .burst_cnt_o(cnt4)
   );

   typedef struct {
      logic        start;
      logic        abort;
      logic        load;
      logic [3:0]  stage;
      logic        busy;
      logic        done;
      logic        swr;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input int n, input logic st, input logic ld, input logic [3:0] stg,
                      input logic bsy, input logic dn, input logic swr, input logic [15:0] c);
      vec_t v;
      for (int i = 0; i < n; i++) begin
         v.start = (i == 0) ? st : 1'b0;
         v.abort = 1'b0;
         v.load  = ld;
         v.stage = stg;
         v.busy  = bsy;
         v.done  = dn;
         v.swr   = swr;
         v.cnt   = c;
         tbl.push_back(v);
      end
   endtask

   task automatic run_table(input string tag);
      foreach (tbl[i]) begin
         start = tbl[i].start;
         abort = tbl[i].abort;
         tick();
         start = 1'b0;
         chk({tag, "_load"},  {31'b0, load_en}, {31'b0, tbl[i].load});
         chk({tag, "_stage"}, {28'b0, stage_en}, {28'b0, tbl[i].stage});
         chk({tag, "_busy"},  {31'b0, busy},    {31'b0, tbl[i].busy});
         chk({tag, "_done"},  {31'b0, done},    {31'b0, tbl[i].done});
         chk({tag, "_swr"},   {31'b0, seed_wr}, {31'b0, tbl[i].swr});
         chk({tag, "_cnt"},   {16'b0, cnt},     {16'b0, tbl[i].cnt});
      end
      tbl.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; start4 = 1'b0; abort4 = 1'b0;
      on_cyc = '0; off_cyc = '0; ramp_cyc = '0; bursts = '0; bursts4 = '0; seed = '0;
      tick();
      tick();
      chk("rst_load",  {31'b0, load_en}, 32'd0);
      chk("rst_stage", {28'b0, stage_en}, 32'd0);
      chk("rst_busy",  {31'b0, busy}, 32'd0);
      chk("rst_done",  {31'b0, done}, 32'd0);
      chk("rst_swr",   {31'b0, seed_wr}, 32'd0);
      chk("rst_cnt",   {16'b0, cnt}, 32'd0);
      chk("rst_seed",  seed_o, 32'd0);
      chk("rst_busy4", {31'b0, busy4}, 32'd0);
      rst = 1'b0;
      tick();

      // 1: two plain bursts, on=5 off=3.
      on_cyc = 32'd5; off_cyc = 32'd3; ramp_cyc = 16'd0; bursts = 16'd2; seed = 32'hDEADBEEF;
      add(1, 1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1, 16'd0);
      add(4, 1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 16'd0);
      add(3, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 16'd1);
      add(5, 1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 16'd1);
      add(1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 16'd2);
      add(1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'd2);
      run_table("t1");
      chk("t1_seed", seed_o, 32'hDEADBEEF);

      // 2: ramped single burst, ramp=2 on=4.
      on_cyc = 32'd4; off_cyc = 32'd7; ramp_cyc = 16'd2; bursts = 16'd1; seed = 32'h0BADF00D;
      add(1, 1'b1, 1'b1, 4'h1, 1'b1, 1'b0, 1'b1, 16'd0);
      add(1, 1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 16'd0);
      add(2, 1'b0, 1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 16'd0);
      add(2, 1'b0, 1'b1, 4'h7, 1'b1, 1'b0, 1'b0, 16'd0);
      add(6, 1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 16'd0);
      add(1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 16'd1);
      add(1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'd1);
      run_table("t2");
      chk("t2_seed", seed_o, 32'h0BADF00D);

      // 3: infinite back-to-back bursts with counter wrap, then abort.
      on_cyc = 32'd1; off_cyc = 32'd0; ramp_cyc = 16'd0; bursts4 = 4'd0;
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      chk("t3_load_first", {31'b0, load_en4}, 32'd1);
      chk("t3_cnt_first",  {28'b0, cnt4}, 32'd0);
      for (int k = 2; k <= 20; k++) begin
         tick();
         chk("t3_load", {31'b0, load_en4}, 32'd1);
         chk("t3_cnt",  {28'b0, cnt4}, 32'((k - 1) % 16));
      end
      abort4 = 1'b1;
      tick();
      abort4 = 1'b0;
      chk("t3_abort_done", {31'b0, done4}, 32'd1);
      chk("t3_abort_load", {31'b0, load_en4}, 32'd0);
      chk("t3_abort_cnt",  {28'b0, cnt4}, 32'd3);
      tick();
      chk("t3_idle_busy",  {31'b0, busy4}, 32'd0);
      chk("t3_idle_done",  {31'b0, done4}, 32'd0);

      // 4: abort in the very cycle ON expires.
      on_cyc = 32'd3; off_cyc = 32'd2; ramp_cyc = 16'd0; bursts = 16'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("t4_pre_load", {31'b0, load_en}, 32'd1);
      chk("t4_pre_cnt",  {16'b0, cnt}, 32'd0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t4_done",  {31'b0, done}, 32'd1);
      chk("t4_load",  {31'b0, load_en}, 32'd0);
      chk("t4_stage", {28'b0, stage_en}, 32'd0);
      chk("t4_cnt",   {16'b0, cnt}, 32'd0);
      tick();
      chk("t4_busy",  {31'b0, busy}, 32'd0);

      // 5: zero-length sequence, then start+abort and abort alone in IDLE.
      on_cyc = 32'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t5_done", {31'b0, done}, 32'd1);
      chk("t5_swr",  {31'b0, seed_wr}, 32'd0);
      chk("t5_load", {31'b0, load_en}, 32'd0);
      chk("t5_busy", {31'b0, busy}, 32'd1);
      tick();
      chk("t5_end_busy", {31'b0, busy}, 32'd0);
      chk("t5_end_done", {31'b0, done}, 32'd0);
      on_cyc = 32'd5;
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0;
      chk("t5_sa_busy", {31'b0, busy}, 32'd0);
      chk("t5_sa_swr",  {31'b0, seed_wr}, 32'd0);
      chk("t5_sa_load", {31'b0, load_en}, 32'd0);
      tick();
      abort = 1'b0;
      chk("t5_ab_busy", {31'b0, busy}, 32'd0);
      chk("t5_ab_done", {31'b0, done}, 32'd0);

      // 6: start and config change while busy are ignored.
      on_cyc = 32'd6; off_cyc = 32'd0; ramp_cyc = 16'd0; bursts = 16'd1;
      start = 1'b1;
      tick();
      on_cyc = 32'd2;
      tick();
      start = 1'b0;
      chk("t6_busy_swr",  {31'b0, seed_wr}, 32'd0);
      chk("t6_busy_load", {31'b0, load_en}, 32'd1);
      tick();
      chk("t6_e3_done", {31'b0, done}, 32'd0);
      tick();
      tick();
      tick();
      chk("t6_e6_load", {31'b0, load_en}, 32'd1);
      tick();
      chk("t6_e7_done", {31'b0, done}, 32'd1);
      chk("t6_e7_cnt",  {16'b0, cnt}, 32'd1);
      tick();

      // 6b: reset in the middle of ON, then restart.
      on_cyc = 32'd10; seed = 32'h12345678;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6r_load",  {31'b0, load_en}, 32'd0);
      chk("t6r_stage", {28'b0, stage_en}, 32'd0);
      chk("t6r_busy",  {31'b0, busy}, 32'd0);
      chk("t6r_done",  {31'b0, done}, 32'd0);
      chk("t6r_swr",   {31'b0, seed_wr}, 32'd0);
      chk("t6r_seed",  seed_o, 32'd0);
      on_cyc = 32'd2; bursts = 16'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t6s_busy", {31'b0, busy}, 32'd1);
      chk("t6s_swr",  {31'b0, seed_wr}, 32'd1);
      chk("t6s_seed", seed_o, 32'h12345678);
      tick();
      tick();
      chk("t6s_done", {31'b0, done}, 32'd1);
      chk("t6s_cnt",  {16'b0, cnt}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
